// File: rtl/aes_serial_pkg.sv
// Definitions shared by both ends of the AES serial link: FSM states, data width,
// default response offset and the legal key-width check.
package aes_serial_pkg;

    typedef enum logic [2:0] {IDLE, RX, WAIT, TX, DONE} state_t;

    localparam int DATA_W             = 128;
    localparam int RESP_DELAY_DEFAULT = 20;

    function automatic bit key_width_legal(input int n);
        return (n == 128) || (n == 192) || (n == 256);
    endfunction

endpackage

// File: rtl/aes_serial_shifter.sv
// LSB-first shift register: parallel load, shift right with serial input at the MSB, or hold.
module aes_serial_shifter #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic         sin,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {sin, q[W-1:1]};
        end
    end

endmodule

// File: rtl/spi_aes_responder.sv
// Target-side AES serial front end: deserialises data+key, drives the core handshake,
// and serialises the core result back at a fixed offset from the last frame bit.
module spi_aes_responder
    import aes_serial_pkg::*;
#(
    parameter int N          = 128,
    parameter int RESP_DELAY = RESP_DELAY_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              chip,
    input  logic              in,
    output logic              out,
    output logic              core_start,
    output logic [DATA_W-1:0] core_data,
    output logic [N-1:0]      core_key,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              busy,
    output logic              frame_err
);

    localparam int FW = DATA_W + N;
    localparam int BW = $clog2(FW + 1);
    localparam int DW = $clog2(RESP_DELAY + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(FW - 1);
    localparam logic [BW-1:0] TX_BITS  = BW'(DATA_W);
    localparam logic [DW-1:0] DLY_LAST = DW'(RESP_DELAY - 1);

    if (!key_width_legal(N) || RESP_DELAY < 2) begin : g_bad_params
        $error("spi_aes_responder: illegal N or RESP_DELAY");
    end

    state_t            state, state_d;
    logic [BW-1:0]     bcnt, bcnt_d;
    logic [DW-1:0]     dcnt, dcnt_d;
    logic              out_d, start_d, err_d, captured, captured_d;
    logic              rx_shift, tx_load, tx_shift, frame_end;
    logic [FW-1:0]     rx_q, rx_next;
    logic [DATA_W-1:0] tx_q;
    logic              unused_bits;

    aes_serial_shifter #(.W(FW)) u_rx (
        .clk   (clk),
        .reset (reset),
        .load  (1'b0),
        .shift (rx_shift & enable),
        .sin   (in),
        .din   ('0),
        .q     (rx_q)
    );

    aes_serial_shifter #(.W(DATA_W)) u_tx (
        .clk   (clk),
        .reset (reset),
        .load  (tx_load & enable),
        .shift (tx_shift & enable),
        .sin   (1'b0),
        .din   (core_result),
        .q     (tx_q)
    );

    // The last frame bit goes straight into core_data/core_key without waiting a cycle.
    assign rx_next     = {in, rx_q[FW-1:1]};
    assign unused_bits = ^{rx_q[0], tx_q[DATA_W-1:1]};
    assign busy        = (state == RX) || (state == WAIT) || (state == TX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        bcnt_d     = bcnt;
        dcnt_d     = dcnt;
        out_d      = out;
        start_d    = 1'b0;
        err_d      = frame_err;
        captured_d = captured;
        rx_shift   = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        frame_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!chip) begin
                    rx_shift = 1'b1;
                    bcnt_d   = BW'(1);
                    state_d  = RX;
                end
            end
            RX: begin
                if (chip) begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    rx_shift = 1'b1;
                    if (bcnt == LAST_BIT) begin
                        frame_end  = 1'b1;
                        start_d    = 1'b1;
                        state_d    = WAIT;
                        bcnt_d     = '0;
                        dcnt_d     = '0;
                        captured_d = 1'b0;
                    end else begin
                        bcnt_d = bcnt + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (chip) begin
                    state_d    = IDLE;
                    dcnt_d     = '0;
                    captured_d = 1'b0;
                    out_d      = 1'b0;
                end else begin
                    if (core_done && !captured) begin
                        tx_load    = 1'b1;
                        captured_d = 1'b1;
                    end
                    // Delay counter saturates one short of RESP_DELAY; the edge seen
                    // in that state is T0+RESP_DELAY, and every later edge is late.
                    if (dcnt == DLY_LAST) begin
                        if (captured) begin
                            state_d    = TX;
                            out_d      = tx_q[0];
                            tx_shift   = 1'b1;
                            bcnt_d     = BW'(1);
                            dcnt_d     = '0;
                            captured_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        dcnt_d = dcnt + 1'b1;
                    end
                end
            end
            TX: begin
                if (chip) begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                    out_d   = 1'b0;
                end else if (bcnt == TX_BITS) begin
                    state_d = DONE;
                    bcnt_d  = '0;
                    out_d   = 1'b0;
                end else begin
                    out_d    = tx_q[0];
                    tx_shift = 1'b1;
                    bcnt_d   = bcnt + 1'b1;
                end
            end
            DONE: begin
                if (chip) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt       <= '0;
            dcnt       <= '0;
            out        <= 1'b0;
            core_start <= 1'b0;
            frame_err  <= 1'b0;
            captured   <= 1'b0;
            core_data  <= '0;
            core_key   <= '0;
        end else if (enable) begin
            bcnt       <= bcnt_d;
            dcnt       <= dcnt_d;
            out        <= out_d;
            core_start <= start_d;
            frame_err  <= err_d;
            captured   <= captured_d;
            if (frame_end) begin
                core_data <= rx_next[DATA_W-1:0];
                core_key  <= rx_next[FW-1:DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_spi_aes_responder.sv
// Directed bench for spi_aes_responder: N=128 and N=256 instances behind a shared mock core.
module tb_spi_aes_responder;

    localparam int D = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic chip = 1'b1;
    logic in_bit = 1'b0;
    logic sel = 1'b0;
    logic core_done = 1'b0;
    logic [127:0] core_result = '0;

    logic chip128, chip256;
    logic out128, out256, start128, start256, busy128, busy256, err128, err256;
    logic [127:0] data128, data256, key128;
    logic [255:0] key256;

    logic out_m, start_m, busy_m, err_m;
    logic [127:0] data_m;
    logic [255:0] key_m;

    int n_checks = 0;
    int n_errs = 0;
    int mock_lat = 5;

    always #5 clk = ~clk;

    assign chip128 = sel | chip;
    assign chip256 = ~sel | chip;
    assign out_m   = sel ? out256 : out128;
    assign start_m = sel ? start256 : start128;
    assign busy_m  = sel ? busy256 : busy128;
    assign err_m   = sel ? err256 : err128;
    assign data_m  = sel ? data256 : data128;
    assign key_m   = sel ? key256 : {128'b0, key128};

    spi_aes_responder #(.N(128), .RESP_DELAY(D)) dut128 (
        .clk(clk), .reset(reset), .enable(enable), .chip(chip128), .in(in_bit),
        .out(out128), .core_start(start128), .core_data(data128), .core_key(key128),
        .core_done(core_done), .core_result(core_result), .busy(busy128), .frame_err(err128)
    );

    spi_aes_responder #(.N(256), .RESP_DELAY(D)) dut256 (
        .clk(clk), .reset(reset), .enable(enable), .chip(chip256), .in(in_bit),
        .out(out256), .core_start(start256), .core_data(data256), .core_key(key256),
        .core_done(core_done), .core_result(core_result), .busy(busy256), .frame_err(err256)
    );

    // Mock core: result = data ^ key[127:0], done pulse a programmable time after start.
    int unsigned mcnt = 0;
    logic mstart_q = 1'b0;
    logic [127:0] mres = '0;
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (reset) begin
            mcnt = 0;
            mstart_q = 1'b0;
        end else begin
            if (mcnt != 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    core_done <= 1'b1;
                    core_result <= mres;
                end
            end else if (start_m && !mstart_q) begin
                mres = data_m ^ key_m[127:0];
                mcnt = mock_lat;
            end
            mstart_q = start_m;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        chip = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [127:0] data, input logic [255:0] key, input int nbits,
                             input int lat, input logic [127:0] exp_res, input logic err_before,
                             input logic late, input int rx_pause, input int tx_pause, input int rst_at);
        logic [127:0] got;
        int bad;
        int t;
        got = '0;
        mock_lat = lat;
        for (int i = 0; i < 128 + nbits; i++) begin
            @(negedge clk);
            if (i == rx_pause) begin
                enable = 1'b0;
                repeat (7) @(negedge clk);
                enable = 1'b1;
            end
            chip = 1'b0;
            in_bit = (i < 128) ? data[i] : key[i-128];
        end
        @(posedge clk);
        @(negedge clk);
        check("start_pulse", start_m, 1'b1);
        check("busy_wait", busy_m, 1'b1);
        check("core_data", data_m, data);
        check("core_key", key_m, key);
        @(negedge clk);
        check("start_single", start_m, 1'b0);
        repeat (D - 2) @(negedge clk);
        check("out_before_tx", out_m, 1'b0);
        check("err_before_tx", err_m, err_before);
        if (late) begin
            @(negedge clk);
            check("late_err", err_m, 1'b1);
            bad = 0;
            t = 0;
            while (!core_done && t < 200) begin
                if (out_m !== 1'b0) bad++;
                @(negedge clk);
                t++;
            end
            check("late_done_seen", core_done, 1'b1);
            @(negedge clk);
            if (out_m !== 1'b0) bad++;
            check("late_out_zero", bad, 0);
        end
        for (int j = 0; j < 128; j++) begin
            @(negedge clk);
            got[j] = out_m;
            if (j == rst_at) begin
                reset = 1'b1;
                #1;
                check("rst_out", out_m, 1'b0);
                check("rst_busy", busy_m, 1'b0);
                check("rst_data", data_m, '0);
                check("rst_err", err_m, 1'b0);
                chip = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (j == tx_pause) begin
                enable = 1'b0;
                bad = 0;
                repeat (7) begin
                    @(negedge clk);
                    if (out_m !== got[j]) bad++;
                end
                enable = 1'b1;
                check("tx_hold", bad, 0);
            end
        end
        check("result_stream", got, exp_res);
        @(negedge clk);
        check("out_after_tx", out_m, 1'b0);
        check("busy_done", busy_m, 1'b0);
        check("err_end", err_m, err_before | late);
        chip = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        logic [255:0] k1;
        d  = 128'h00112233_44556677_8899aabb_ccddeeff;
        k1 = {128'b0, 128'h00010203_04050607_08090a0b_0c0d0e0f};

        repeat (2) @(negedge clk);
        check("reset_out", {out128, out256}, 2'b00);
        check("reset_start", {start128, start256}, 2'b00);
        check("reset_busy_err", {busy128, busy256, err128, err256}, 4'b0000);
        check("reset_data", {data128, data256}, '0);
        check("reset_key", {key128, key256}, '0);
        reset = 1'b0;
        @(negedge clk);

        sel = 1'b0;
        run_frame(d, k1, 128, 5, 128'h00102030_40506070_8090a0b0_c0d0e0f0, 1'b0, 1'b0, -1, -1, -1);

        sel = 1'b1;
        run_frame(d, {256{1'b1}}, 256, 5, 128'hffeeddcc_bbaa9988_77665544_33221100, 1'b0, 1'b0, -1, -1, -1);

        sel = 1'b0;
        run_frame(d, k1, 128, 5, 128'h00102030_40506070_8090a0b0_c0d0e0f0, 1'b0, 1'b0, 50, 40, -1);

        do_reset();
        run_frame(d, k1, 128, 30, 128'h00102030_40506070_8090a0b0_c0d0e0f0, 1'b0, 1'b1, -1, -1, -1);

        do_reset();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chip = 1'b0;
            in_bit = d[i];
        end
        @(negedge clk);
        chip = 1'b1;
        @(negedge clk);
        check("abort_busy", busy_m, 1'b0);
        check("abort_err", err_m, 1'b1);
        check("abort_no_start", start_m, 1'b0);
        run_frame(d, k1, 128, 5, 128'h00102030_40506070_8090a0b0_c0d0e0f0, 1'b1, 1'b0, -1, -1, -1);

        run_frame(d, k1, 128, 5, 128'h00102030_40506070_8090a0b0_c0d0e0f0, 1'b1, 1'b0, -1, -1, 64);
        run_frame(d, k1, 128, 5, 128'h00102030_40506070_8090a0b0_c0d0e0f0, 1'b0, 1'b0, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
